// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one single-port 32-bit BRAM between two requesters. Port A (CPU
// pipeline) has fixed priority. Port B (boot loader / DMA) is protected by
// an anti-starvation counter: after MAX_WAIT consecutive denied cycles while
// requesting, B takes the next slot even if A is requesting.
//
// Handshake (both ports): a requester raises x_req together with x_write,
// x_wmask, x_wdata and x_addr, and holds all of them stable until it sees
// x_gnt=1. x_gnt is combinational and means "accepted this cycle"; the
// access is presented to the BRAM in that same cycle. A read completes one
// cycle later with x_rvalid=1 and x_rdata carrying the BRAM word. Writes
// never produce x_rvalid. Dropping x_req before a grant is allowed.

module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [3:0]            a_wmask,
    input  logic [31:0]           a_wdata,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [31:0]           a_rdata,

    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [3:0]            b_wmask,
    input  logic [31:0]           b_wdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [31:0]           b_rdata,

    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    // Saturation value of the 4-bit wait counter (MAX_WAIT is 1..15).
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       b_pri;
    logic       rd_a;
    logic       rd_b;

    // Grant decision: A wins by default, B wins when A is idle or when B has
    // been denied MAX_WAIT cycles in a row. Grants are held off during reset.
    always_comb begin
        b_pri = b_req && (wait_cnt == WAIT_MAX);
        b_gnt = rstn && b_req && (!a_req || b_pri);
        a_gnt = rstn && a_req && !b_gnt;
    end

    // Memory mux: the granted port drives the BRAM; with no grant the
    // address/data lines follow port A and no write strobe is issued.
    always_comb begin
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
        mem_wmask = a_wmask;
        if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_wmask = b_wmask;
        end
        mem_write = (a_gnt && a_write) || (b_gnt && b_write);
    end

    // Anti-starvation counter: counts consecutive denied cycles of a pending
    // B request, saturating at MAX_WAIT; cleared by a B grant or idle B.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= 4'd0;
        end else if (b_gnt || !b_req) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Read-return tracking: remembers which port owns the BRAM word that
    // arrives in the next cycle. Reset discards any response in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_a <= 1'b0;
            rd_b <= 1'b0;
        end else begin
            rd_a <= a_gnt && !a_write;
            rd_b <= b_gnt && !b_write;
        end
    end

    // Response steering: read data is routed only to the owning port and
    // forced to zero elsewhere.
    always_comb begin
        a_rvalid = rd_a;
        b_rvalid = rd_b;
        a_rdata  = rd_a ? mem_rdata : 32'h0;
        b_rdata  = rd_b ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: a behavioural BRAM with one-cycle read
// latency, a table of per-cycle vectors with hand-computed outputs, and a
// hand-written asynchronous reset sequence.

module tb_bram_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        a_req, a_write, b_req, b_write;
  logic [3:0]  a_wmask, b_wmask;
  logic [31:0] a_wdata, b_wdata;
  logic [10:0] a_addr, b_addr;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        a_req;
    logic        a_write;
    logic [3:0]  a_wmask;
    logic [31:0] a_wdata;
    logic [10:0] a_addr;
    logic        b_req;
    logic        b_write;
    logic [3:0]  b_wmask;
    logic [31:0] b_wdata;
    logic [10:0] b_addr;
    logic        e_a_gnt;
    logic        e_b_gnt;
    logic        e_mem_write;
    logic [10:0] e_mem_addr;
    logic        e_a_rvalid;
    logic [31:0] e_a_rdata;
    logic        e_b_rvalid;
    logic [31:0] e_b_rdata;
  } vec_t;

  vec_t vecs[$];

  bram_port_arbiter #(.ADDR_WIDTH(11), .MAX_WAIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata),
    .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: byte-masked writes, registered read of the presented address
  logic        preload;
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      mem[5]     <= 32'h12345678;
      mem[11'h10] <= 32'h11223344;
    end else if (mem_write) begin
      for (int k = 0; k < 4; k++)
        if (mem_wmask[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
    mem_rdata <= mem[mem_addr];
  end

  function automatic vec_t mk(input int ar, input int aw, input int am, input int ad, input int aa,
                              input int br, input int bw, input int bm, input int bd, input int ba,
                              input int eag, input int ebg, input int emw, input int ema,
                              input int earv, input int eard, input int ebrv, input int ebrd);
    vec_t v;
    v.a_req = 1'(ar);  v.a_write = 1'(aw);  v.a_wmask = 4'(am);  v.a_wdata = 32'(ad);  v.a_addr = 11'(aa);
    v.b_req = 1'(br);  v.b_write = 1'(bw);  v.b_wmask = 4'(bm);  v.b_wdata = 32'(bd);  v.b_addr = 11'(ba);
    v.e_a_gnt = 1'(eag);  v.e_b_gnt = 1'(ebg);  v.e_mem_write = 1'(emw);  v.e_mem_addr = 11'(ema);
    v.e_a_rvalid = 1'(earv);  v.e_a_rdata = 32'(eard);
    v.e_b_rvalid = 1'(ebrv);  v.e_b_rdata = 32'(ebrd);
    return v;
  endfunction

  // scoreboard comparison
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    a_req = v.a_req;  a_write = v.a_write;  a_wmask = v.a_wmask;  a_wdata = v.a_wdata;  a_addr = v.a_addr;
    b_req = v.b_req;  b_write = v.b_write;  b_wmask = v.b_wmask;  b_wdata = v.b_wdata;  b_addr = v.b_addr;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, " a_gnt"}, 32'(a_gnt), 32'(v.e_a_gnt));
    chk({tag, " b_gnt"}, 32'(b_gnt), 32'(v.e_b_gnt));
    chk({tag, " mem_write"}, 32'(mem_write), 32'(v.e_mem_write));
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_mem_addr));
    chk({tag, " a_rvalid"}, 32'(a_rvalid), 32'(v.e_a_rvalid));
    chk({tag, " a_rdata"}, a_rdata, v.e_a_rdata);
    chk({tag, " b_rvalid"}, 32'(b_rvalid), 32'(v.e_b_rvalid));
    chk({tag, " b_rdata"}, b_rdata, v.e_b_rdata);
    if (v.e_mem_write) begin
      chk({tag, " mem_wdata"}, mem_wdata, v.e_b_gnt ? v.b_wdata : v.a_wdata);
      chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(v.e_b_gnt ? v.b_wmask : v.a_wmask));
    end
  endtask

  // one cycle: drive at the falling edge, sample 1 ns later
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check_vec(v, tag);
  endtask

  localparam int C1 = 'hC0DE0001;
  localparam int C2 = 'hC0DE0002;
  localparam int C3 = 'hC0DE0003;

  initial begin
    vec_t v;
    // single A read of 0x005
    vecs.push_back(mk(1,0,0,0,5,  0,0,0,0,0,  1,0,0,5,  0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  1,'h12345678,0,0));
    // A and B both reading continuously: B wins every fifth cycle
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  0,0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  0,1,0,2,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  0,0,1,C2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  0,1,0,2,  1,C1,0,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  0,0,1,C2));
    // B masked write, A readback, A write with empty mask
    vecs.push_back(mk(0,0,0,0,0,  1,1,'b0011,'hAABBCCDD,'h10,  0,1,1,'h10,  0,0,0,0));
    vecs.push_back(mk(1,0,0,0,'h10,  0,0,0,0,0,  1,0,0,'h10,  0,0,0,0));
    vecs.push_back(mk(1,1,0,'hFFFFFFFF,5,  0,0,0,0,0,  1,0,1,5,  1,'h1122CCDD,0,0));
    vecs.push_back(mk(1,0,0,0,5,  0,0,0,0,0,  1,0,0,5,  0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  1,'h12345678,0,0));
    // B denied 3 cycles, drops req, re-requests: needs 4 fresh denials
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,1,  0,0,0,0,2,  1,0,0,1,  1,C1,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,1,  1,0,0,0,2,  0,1,0,2,  1,C1,0,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  0,0,1,C2));
    // alternating uncontended reads A, B, A
    vecs.push_back(mk(1,0,0,0,1,  0,0,0,0,0,  1,0,0,1,  0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  1,0,0,0,2,  0,1,0,2,  1,C1,0,0));
    vecs.push_back(mk(1,0,0,0,3,  0,0,0,0,0,  1,0,0,3,  0,0,1,C2));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  1,C3,0,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  0,0,0,0));

    // reset: requests present but nothing may be granted or written
    preload = 1'b1;
    rstn = 1'b0;
    drive(mk(1,1,'hF,'h55AA55AA,7,  1,1,'hF,'h0,8,  0,0,0,0,  0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset a_gnt", 32'(a_gnt), 32'd0);
    chk("reset b_gnt", 32'(b_gnt), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset a_rvalid", 32'(a_rvalid), 32'd0);
    chk("reset b_rvalid", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    drive(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  0,0,0,0));
    rstn = 1'b1;
    preload = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset with the counter at 3 and an A read granted
    v = mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  0,0,0,0);
    run_vec(v, "rst_seq0");
    v = mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0);
    run_vec(v, "rst_seq1");
    run_vec(v, "rst_seq2");
    run_vec(v, "rst_seq3");
    @(posedge clk);
    #2;
    chk("pre-reset a_rvalid", 32'(a_rvalid), 32'd1);
    // B turns into a writer with A idle, so only reset can hold off b_gnt
    a_req = 1'b0;
    b_write = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    chk("async rst a_rvalid", 32'(a_rvalid), 32'd0);
    chk("async rst a_rdata", a_rdata, 32'd0);
    chk("async rst b_rvalid", 32'(b_rvalid), 32'd0);
    chk("async rst a_gnt", 32'(a_gnt), 32'd0);
    chk("async rst b_gnt", 32'(b_gnt), 32'd0);
    chk("async rst mem_write", 32'(mem_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    // counter restarts from 0: four A grants, then B
    v = mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  0,0,0,0);
    drive(v);
    #1;
    check_vec(v, "post_rst0");
    v = mk(1,0,0,0,1,  1,0,0,0,2,  1,0,0,1,  1,C1,0,0);
    run_vec(v, "post_rst1");
    run_vec(v, "post_rst2");
    run_vec(v, "post_rst3");
    run_vec(mk(1,0,0,0,1,  1,0,0,0,2,  0,1,0,2,  1,C1,0,0), "post_rst4");
    run_vec(mk(0,0,0,0,0,  0,0,0,0,0,  0,0,0,0,  0,0,1,C2), "post_rst5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port 32-bit BRAM main memory between two requesters.
- Port A is the CPU pipeline and has fixed priority. Port B is a secondary master, e.g. a UART boot loader or DMA writing program images.
- An anti-starvation counter guarantees B a slot after MAX_WAIT consecutive lost cycles.
- Sits between the pipeline/loader and the BRAM memory; BRAM read data arrives one cycle after the address.

Parameters:
- ADDR_WIDTH, 11, word-address width driven to the BRAM (2048 words = 8 KiByte).
- MAX_WAIT, 4, consecutive cycles B may be denied while requesting before it wins over A; legal range 1..15.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- a_req  in  1  port A access request (held until granted)
- a_write  in  1  A: 1 = write, 0 = read
- a_wmask  in  4  A byte-write enables, bit i covers wdata[8i+7:8i]
- a_wdata  in  32  A write data
- a_addr  in  ADDR_WIDTH  A word address
- a_gnt  out  1  A request accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid (one cycle after read grant)
- a_rdata  out  32  A read data, 0 when a_rvalid=0
- b_req, b_write, b_wmask, b_wdata, b_addr  in  1/1/4/32/ADDR_WIDTH  port B, same meaning as A
- b_gnt, b_rvalid  out  1/1  port B, same meaning as A
- b_rdata  out  32  port B, same meaning as A
- mem_write  out  1  BRAM write strobe
- mem_wmask  out  4  BRAM byte mask
- mem_wdata  out  32  BRAM write data
- mem_addr  out  ADDR_WIDTH  BRAM word address
- mem_rdata  in  32  BRAM registered read data

Behaviour:
- Reset (rstn=0, asynchronous): wait counter=0, a_rvalid=b_rvalid=0. While rstn=0, a_gnt=b_gnt=0 and mem_write=0 regardless of requests.
- Grant rule, combinational, evaluated every cycle:
  - b_pri = b_req && (wait_cnt == MAX_WAIT).
  - b_gnt = b_req && (!a_req || b_pri).
  - a_gnt = a_req && !b_gnt.
  - At most one grant per cycle; a_gnt and b_gnt are never both 1.
- Memory mux:
  - mem_addr, mem_wdata and mem_wmask come from the granted port. With no grant, they come from port A, and mem_write=0.
  - mem_write = (a_gnt && a_write) || (b_gnt && b_write).
  - mem_wmask is passed through unchanged. A write with wmask=0 is legal and is still granted (no-op).
- Read return:
  - Registered flags: rd_a <= a_gnt && !a_write; rd_b <= b_gnt && !b_write.
  - a_rvalid=rd_a, b_rvalid=rd_b.
  - x_rdata = mem_rdata when x_rvalid, else 0.
  - Read latency is exactly 1 cycle after the grant cycle.
  - Back-to-back reads from alternating ports are supported at one per cycle, with no bubbles.
- Writes produce no rvalid.
- Wait counter (width 4):
  - Increments when b_req && !b_gnt, saturating at MAX_WAIT.
  - Clears to 0 when b_gnt=1 or b_req=0.
- Requesters may change address, data or req only after seeing gnt. Dropping req before grant is legal and clears the counter.
- Simultaneous events:
  - B wins at counter==MAX_WAIT even if A requests; A stalls exactly one cycle.
  - A read grant in the cycle in which an earlier A read returns is normal pipelining.
- Reset mid-transaction: a pending rvalid is discarded (forced 0), and the counter restarts from 0.

Test Plan:
- Only a_req, read addr 0x005, BRAM mem[5]=0x12345678 -> a_gnt=1 same cycle, mem_addr=0x005, mem_write=0; next cycle a_rvalid=1, a_rdata=0x12345678, b_rvalid=0, b_rdata=0.
- a_req and b_req held high continuously, both reads, MAX_WAIT=4 -> a_gnt in cycles 0-3, b_gnt in cycle 4, a_gnt 5-8, b_gnt 9; pattern repeats with period 5; every rvalid routed to the port granted in the prior cycle.
- b_write=1, addr 0x010, wdata 0xAABBCCDD, wmask 0011, A idle, mem[0x10]=0x11223344 -> b_gnt=1, mem_write=1; subsequent A read of 0x010 returns 0x1122CCDD; no b_rvalid.
- B requests under A contention for 3 cycles, drops b_req 1 cycle, re-requests -> counter returns to 0; B granted only after 4 further denied cycles (cycle 4 of the new request).
- Counter at 3 with an A read granted, then rstn pulsed low asynchronously mid-cycle -> a_rvalid, b_rvalid, a_gnt, b_gnt and mem_write go to 0 immediately; after release the counter counts from 0.
- Alternating single-cycle reads A@0x001, B@0x002, A@0x003 with no contention -> rvalid sequence a, b, a on consecutive cycles with matching data; no lost or duplicated responses.
